// File: rtl/noise_table_loader_if.sv
// Host word channel (valid/ready) and generator table-load channel used by noise_table_loader.
// master = host/generator side, slave = the loader.
interface noise_table_loader_if #(
    parameter int DATA_W = 64,
    parameter int LOC_W  = 8
);
    logic [DATA_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] mem_data;
    logic [LOC_W-1:0]  location;
    logic              load_mem;
    logic              done_wait;

    modport master (
        output wr_data,
        output wr_valid,
        output done_wait,
        input  wr_ready,
        input  mem_data,
        input  location,
        input  load_mem
    );

    modport slave (
        input  wr_data,
        input  wr_valid,
        input  done_wait,
        output wr_ready,
        output mem_data,
        output location,
        output load_mem
    );
endinterface

// File: rtl/noise_table_loader.sv
// Writes a host word stream into the noise generator table, then waits for done_wait.
// Optional XOR checksum of written words: define NOISE_LOADER_CHECKSUM_EN.
module noise_table_loader #(
    parameter int DEPTH   = 128,
    parameter int DATA_W  = 64,
    parameter int LOC_W   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [LOC_W:0]      entry_count,
    input  logic                abort,
    noise_table_loader_if.slave bus,
    output logic                busy,
    output logic                cfg_done,
    output logic [1:0]          err
`ifdef NOISE_LOADER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0]   checksum
`endif
);

    localparam int              TO_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [LOC_W:0]  DEPTH_C = (LOC_W + 1)'(DEPTH);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD     = 2'd1,
        WAIT_RDY = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t            state_r;
    logic [LOC_W:0]    count_r;
    logic [LOC_W:0]    idx_r;
    logic [TO_W-1:0]   tcnt_r;
    logic              wr_ready_r;
    logic [DATA_W-1:0] mem_data_r;
    logic [LOC_W-1:0]  location_r;
    logic              load_mem_r;
    logic              busy_r;
    logic              cfg_done_r;
    logic [1:0]        err_r;

    logic              accept_s;
    logic              count_ok_s;
    logic              last_s;

`ifdef NOISE_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_r;

    function automatic logic [DATA_W-1:0] fold_word(input logic [DATA_W-1:0] acc,
                                                    input logic [DATA_W-1:0] word);
        return acc ^ word;
    endfunction

    assign checksum = checksum_r;
`endif

    assign accept_s   = bus.wr_valid & wr_ready_r;
    assign count_ok_s = (entry_count != {(LOC_W + 1){1'b0}}) && (entry_count <= DEPTH_C);
    assign last_s     = (idx_r == (count_r - (LOC_W + 1)'(1)));

    assign bus.wr_ready = wr_ready_r;
    assign bus.mem_data = mem_data_r;
    assign bus.location = location_r;
    assign bus.load_mem = load_mem_r;
    assign busy         = busy_r;
    assign cfg_done     = cfg_done_r;
    assign err          = err_r;

    // Session FSM with all outputs registered; abort outranks every other event in LOAD/WAIT_RDY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            count_r    <= {(LOC_W + 1){1'b0}};
            idx_r      <= {(LOC_W + 1){1'b0}};
            tcnt_r     <= {TO_W{1'b0}};
            wr_ready_r <= 1'b0;
            mem_data_r <= {DATA_W{1'b0}};
            location_r <= {LOC_W{1'b0}};
            load_mem_r <= 1'b0;
            busy_r     <= 1'b0;
            cfg_done_r <= 1'b0;
            err_r      <= 2'b00;
`ifdef NOISE_LOADER_CHECKSUM_EN
            checksum_r <= {DATA_W{1'b0}};
`endif
        end else begin
            load_mem_r <= 1'b0;
            cfg_done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    wr_ready_r <= 1'b0;
                    if (start) begin
                        if (count_ok_s) begin
                            count_r    <= entry_count;
                            idx_r      <= {(LOC_W + 1){1'b0}};
                            err_r      <= 2'b00;
                            busy_r     <= 1'b1;
                            wr_ready_r <= 1'b1;
                            state_r    <= LOAD;
`ifdef NOISE_LOADER_CHECKSUM_EN
                            checksum_r <= {DATA_W{1'b0}};
`endif
                        end else begin
                            err_r <= 2'b01;
                        end
                    end
                end
                LOAD: begin
                    if (abort) begin
                        wr_ready_r <= 1'b0;
                        busy_r     <= 1'b0;
                        state_r    <= IDLE;
`ifdef NOISE_LOADER_CHECKSUM_EN
                        checksum_r <= {DATA_W{1'b0}};
`endif
                    end else if (accept_s) begin
                        load_mem_r <= 1'b1;
                        mem_data_r <= bus.wr_data;
                        location_r <= idx_r[LOC_W-1:0];
                        idx_r      <= idx_r + (LOC_W + 1)'(1);
`ifdef NOISE_LOADER_CHECKSUM_EN
                        checksum_r <= fold_word(checksum_r, bus.wr_data);
`endif
                        // Last word: stop accepting; its strobe lands in the first WAIT_RDY cycle.
                        if (last_s) begin
                            wr_ready_r <= 1'b0;
                            tcnt_r     <= {TO_W{1'b0}};
                            state_r    <= WAIT_RDY;
                        end
                    end
                end
                WAIT_RDY: begin
                    if (abort) begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
`ifdef NOISE_LOADER_CHECKSUM_EN
                        checksum_r <= {DATA_W{1'b0}};
`endif
                    end else begin
                        tcnt_r <= tcnt_r + TO_W'(1);
                        // done_wait is not trusted during the final strobe cycle (tcnt_r == 0).
                        if ((tcnt_r != {TO_W{1'b0}}) && bus.done_wait) begin
                            cfg_done_r <= 1'b1;
                            busy_r     <= 1'b0;
                            state_r    <= DONE;
                        end else if (tcnt_r == TO_LAST) begin
                            err_r   <= {1'b1, err_r[0]};
                            busy_r  <= 1'b0;
                            state_r <= IDLE;
                        end
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    wr_ready_r <= 1'b0;
                    busy_r     <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_noise_table_loader.sv
// Directed self-checking bench for noise_table_loader (DEPTH=128, TIMEOUT=16).
// Checksum checks are compiled in when NOISE_LOADER_CHECKSUM_EN is defined.
module tb_noise_table_loader;

    logic       clk;
    logic       rst;
    logic       start;
    logic [8:0] entry_count;
    logic       abort;
    logic       busy;
    logic       cfg_done;
    logic [1:0] err;
    logic       seen;
    int         checks;
    int         errors;
    logic [7:0] words [3];
    logic [7:0] sums  [3];
`ifdef NOISE_LOADER_CHECKSUM_EN
    logic [63:0] checksum;
`endif

    noise_table_loader_if #(.DATA_W(64), .LOC_W(8)) bus ();

    noise_table_loader #(
        .DEPTH  (128),
        .DATA_W (64),
        .LOC_W  (8),
        .TIMEOUT(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .entry_count(entry_count),
        .abort      (abort),
        .bus        (bus),
        .busy       (busy),
        .cfg_done   (cfg_done),
        .err        (err)
`ifdef NOISE_LOADER_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        words  = '{8'hF0, 8'h0F, 8'hFF};
        sums   = '{8'hF0, 8'hFF, 8'h00};
        rst = 1'b0; start = 1'b0; entry_count = 9'd0; abort = 1'b0;
        bus.wr_data = 64'd0; bus.wr_valid = 1'b0; bus.done_wait = 1'b0;
        #1 rst = 1'b1;
        #11;
        chk("rst_load_mem", 64'(bus.load_mem), 64'd0);
        chk("rst_busy",     64'(busy),         64'd0);
        chk("rst_wr_ready", 64'(bus.wr_ready), 64'd0);
        chk("rst_err",      64'(err),          64'd0);
        chk("rst_cfg_done", 64'(cfg_done),     64'd0);
        chk("rst_location", 64'(bus.location), 64'd0);
        chk("rst_mem_data", bus.mem_data,      64'd0);
        tick();
        rst = 1'b0;
        tick();

        // Four back-to-back words with done_wait already high.
        start = 1'b1; entry_count = 9'd4; bus.done_wait = 1'b1;
        tick();
        start = 1'b0;
        chk("b_busy",  64'(busy),         64'd1);
        chk("b_ready", 64'(bus.wr_ready), 64'd1);
        chk("b_idle_strobe", 64'(bus.load_mem), 64'd0);
        bus.wr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.wr_data = 64'h11 * 64'(i + 1);
            tick();
            chk("b_strobe", 64'({bus.load_mem, bus.location, bus.mem_data[7:0]}),
                64'({1'b1, 8'(i), 8'(17 * (i + 1))}));
        end
        chk("b_ready_drop", 64'(bus.wr_ready), 64'd0);
        bus.wr_valid = 1'b0;
        tick();
        chk("b_strobe_end", 64'(bus.load_mem), 64'd0);
        chk("b_early_done", 64'(cfg_done),     64'd0);
        chk("b_busy_wait",  64'(busy),         64'd1);
        tick();
        chk("b_cfg_done", 64'(cfg_done), 64'd1);
        chk("b_busy_off", 64'(busy),     64'd0);
        tick();
        chk("b_cfg_pulse", 64'(cfg_done), 64'd0);
        chk("b_err",       64'(err),      64'd0);

        // Full 128-entry load with wr_valid toggling every cycle.
        bus.done_wait = 1'b0;
        start = 1'b1; entry_count = 9'd128;
        tick();
        start = 1'b0;
        for (int i = 0; i < 256; i++) begin
            bus.wr_valid = (i % 2 == 0);
            bus.wr_data  = 64'h1000 + 64'(i / 2);
            tick();
            chk("c_seq", 64'({bus.load_mem, bus.location, bus.mem_data[15:0]}),
                64'({(i % 2 == 0), 8'(i / 2), 16'(16'h1000 + 16'(i / 2))}));
        end
        chk("c_ready_drop", 64'(bus.wr_ready), 64'd0);
        chk("c_busy_wait",  64'(busy),         64'd1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen = seen | cfg_done;
        end
        chk("c_no_early_done", 64'(seen), 64'd0);
        bus.done_wait = 1'b1;
        tick();
        chk("c_cfg_done", 64'(cfg_done), 64'd1);
        chk("c_busy_off", 64'(busy),     64'd0);
        bus.done_wait = 1'b0;
        tick();
        chk("c_cfg_pulse", 64'(cfg_done), 64'd0);

        // Illegal counts, then a legal start that runs into the timeout.
        start = 1'b1; entry_count = 9'd0;
        tick();
        chk("d_err_zero",   64'(err),          64'd1);
        chk("d_busy_zero",  64'(busy),         64'd0);
        chk("d_ready_zero", 64'(bus.wr_ready), 64'd0);
        entry_count = 9'd129;
        tick();
        chk("d_err_129",  64'(err),          64'd1);
        chk("d_busy_129", 64'(busy),         64'd0);
        chk("d_no_strobe", 64'(bus.load_mem), 64'd0);
        start = 1'b0;
        tick();
        chk("d_err_sticky", 64'(err), 64'd1);
        start = 1'b1; entry_count = 9'd2;
        bus.wr_valid = 1'b1; bus.wr_data = 64'hAA;
        tick();
        start = 1'b0;
        chk("d_err_clear", 64'(err),  64'd0);
        chk("d_busy_on",   64'(busy), 64'd1);
        tick();
        chk("e_strobe0", 64'({bus.load_mem, bus.location, bus.mem_data[7:0]}), 64'({1'b1, 8'd0, 8'hAA}));
        bus.wr_data = 64'hBB;
        tick();
        chk("e_strobe1", 64'({bus.load_mem, bus.location, bus.mem_data[7:0]}), 64'({1'b1, 8'd1, 8'hBB}));
        bus.wr_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            seen = seen | cfg_done;
        end
        chk("e_busy_before_to", 64'(busy), 64'd1);
        chk("e_err_before_to",  64'(err),  64'd0);
        tick();
        seen = seen | cfg_done;
        chk("e_err_timeout", 64'(err),  64'd2);
        chk("e_busy_off",    64'(busy), 64'd0);
        chk("e_no_cfg_done", 64'(seen), 64'd0);

        // Asynchronous reset in the middle of LOAD after three strobes.
        start = 1'b1; entry_count = 9'd8; bus.wr_valid = 1'b1; bus.wr_data = 64'h55;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk("r_strobe2", 64'({bus.load_mem, bus.location}), 64'({1'b1, 8'd2}));
        #2 rst = 1'b1;
        #1;
        chk("r_load_mem_async", 64'(bus.load_mem), 64'd0);
        chk("r_busy_async",     64'(busy),         64'd0);
        chk("r_ready_async",    64'(bus.wr_ready), 64'd0);
        bus.wr_valid = 1'b0;
        #3 rst = 1'b0;
        tick();
        chk("r_busy_idle",  64'(busy),         64'd0);
        chk("r_err_idle",   64'(err),          64'd0);
        chk("r_ready_idle", 64'(bus.wr_ready), 64'd0);
        chk("r_strobe_idle", 64'(bus.load_mem), 64'd0);

        // Abort after one of three words; a mid-LOAD start is ignored.
        start = 1'b1; entry_count = 9'd3; bus.wr_valid = 1'b1; bus.wr_data = 64'hF0;
        tick();
        start = 1'b0;
        tick();
        chk("f_strobe0", 64'({bus.load_mem, bus.location, bus.mem_data[7:0]}), 64'({1'b1, 8'd0, 8'hF0}));
        bus.wr_valid = 1'b0; start = 1'b1; entry_count = 9'd0;
        tick();
        start = 1'b0;
        chk("f_start_ignored_err", 64'(err),          64'd0);
        chk("f_start_ignored_busy", 64'(busy),        64'd1);
        chk("f_still_ready",       64'(bus.wr_ready), 64'd1);
        abort = 1'b1; bus.wr_valid = 1'b1; bus.wr_data = 64'h0F;
        tick();
        abort = 1'b0; bus.wr_valid = 1'b0;
        chk("f_abort_strobe", 64'(bus.load_mem), 64'd0);
        chk("f_abort_busy",   64'(busy),         64'd0);
        chk("f_abort_ready",  64'(bus.wr_ready), 64'd0);
        chk("f_abort_err",    64'(err),          64'd0);
        chk("f_abort_loc",    64'({bus.location, bus.mem_data[7:0]}), 64'({8'd0, 8'hF0}));
`ifdef NOISE_LOADER_CHECKSUM_EN
        chk("f_abort_checksum", checksum, 64'd0);
`endif
        tick();
        chk("f_no_cfg_done", 64'(cfg_done), 64'd0);

        // Checksum run: F0 ^ 0F ^ FF folds to zero.
        bus.done_wait = 1'b1;
        start = 1'b1; entry_count = 9'd3;
        tick();
        start = 1'b0;
        bus.wr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.wr_data = 64'(words[i]);
            tick();
            chk("g_strobe", 64'({bus.load_mem, bus.location, bus.mem_data[7:0]}),
                64'({1'b1, 8'(i), words[i]}));
`ifdef NOISE_LOADER_CHECKSUM_EN
            chk("g_checksum_run", checksum, 64'(sums[i]));
`endif
        end
        bus.wr_valid = 1'b0;
        tick();
        tick();
        chk("g_cfg_done", 64'(cfg_done), 64'd1);
`ifdef NOISE_LOADER_CHECKSUM_EN
        chk("g_checksum_done", checksum, 64'd0);
`endif
        tick();
        chk("g_cfg_pulse", 64'(cfg_done), 64'd0);
        chk("g_busy_off",  64'(busy),     64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
